// File: rtl/if_else_stream_pkg.sv
// Shared types and golden model for the if_else_stream kernel.
// ie_ref() works on up to 64-bit operands and masks to the requested width.
package if_else_pkg;

    typedef enum logic [1:0] {BR_GT, BR_LT, BR_EQ} branch_t;

    function automatic logic [63:0] ie_ref(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input bit          signed_mode,
                                           input int          width);
        logic [63:0]        mask;
        logic [63:0]        am;
        logic [63:0]        bm;
        logic [63:0]        k;
        logic [63:0]        m;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic               gt;
        logic               lt;
        int                 sh;
        sh   = 64 - width;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        // Sign-extend from bit width-1 by shifting it up to bit 63 and back.
        sa   = $signed(am << sh) >>> sh;
        sb   = $signed(bm << sh) >>> sh;
        if (signed_mode) begin
            gt = sa > sb;
            lt = sa < sb;
        end else begin
            gt = am > bm;
            lt = am < bm;
        end
        k = (am - bm) & mask;
        if (gt) begin
            m = am;
        end else if (lt) begin
            m = bm;
        end else begin
            m = 64'd1;
        end
        return (k * m) & mask;
    endfunction

endpackage

// File: rtl/if_else_stream_if.sv
// Operand join and result handshake bundle for if_else_stream.
// master = producer/consumer side, slave = the kernel.
interface if_else_stream_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a_din;
    logic             a_valid_in;
    logic             a_ready_out;
    logic [WIDTH-1:0] b_din;
    logic             b_valid_in;
    logic             b_ready_out;
    logic [WIDTH-1:0] end_out;
    logic             end_valid;
    logic             end_ready;

    modport master (
        output a_din, a_valid_in, b_din, b_valid_in, end_ready,
        input  a_ready_out, b_ready_out, end_out, end_valid
    );

    modport slave (
        input  a_din, a_valid_in, b_din, b_valid_in, end_ready,
        output a_ready_out, b_ready_out, end_out, end_valid
    );
endinterface

// File: rtl/if_else_stream_elastic_fifo.sv
// Show-ahead result FIFO: rd_data is always the head entry.
// Writes into a full FIFO are dropped; the caller's credit scheme prevents them.
module elastic_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage is reset so the head reads 0 out of reset; at this
    // depth that costs little, and larger FIFOs would drop it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CNT_W'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/if_else_stream.sv
// Streaming k = a - b kernel: k*a if a > b, k*b if b > a, else k.
// Credit-joined operands, S0 register, MUL_LAT-stage multiplier, result FIFO.
module if_else_stream
    import if_else_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2,
    parameter int DEPTH   = 8,
    parameter bit SIGNED  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    if_else_stream_if.slave   io
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (MUL_LAT < 1) begin : g_lat_chk
        $error("MUL_LAT must be >= 1");
    end
    if (DEPTH < MUL_LAT + 2) begin : g_depth_chk
        $error("DEPTH must be >= MUL_LAT + 2");
    end

    logic [CNT_W-1:0] inflight;
    logic             credit;
    logic             accept;
    logic             pop;
    logic             gt;
    logic             lt;
    branch_t          br;
    logic [WIDTH-1:0] k_next;
    logic [WIDTH-1:0] m_next;
    logic             s0_valid;
    logic [WIDTH-1:0] s0_k;
    logic [WIDTH-1:0] s0_m;
    logic [MUL_LAT-1:0] mul_v;
    logic [WIDTH-1:0]   mul_q [MUL_LAT];
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    // Credit comes from registered state only; rst gates it so readies are low in reset.
    assign credit         = rst && (inflight < CNT_W'(DEPTH));
    assign io.a_ready_out = io.b_valid_in && credit;
    assign io.b_ready_out = io.a_valid_in && credit;
    assign accept         = io.a_valid_in && io.b_valid_in && credit;
    assign io.end_valid   = !fifo_empty;
    assign pop            = io.end_valid && io.end_ready;
    assign k_next         = io.a_din - io.b_din;

    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would infer a latch.
    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        if (SIGNED) begin
            gt = $signed(io.a_din) > $signed(io.b_din);
            lt = $signed(io.a_din) < $signed(io.b_din);
        end else begin
            gt = io.a_din > io.b_din;
            lt = io.a_din < io.b_din;
        end
        br = BR_EQ;
        if (gt) begin
            br = BR_GT;
        end else if (lt) begin
            br = BR_LT;
        end
        m_next = WIDTH'(1);
        case (br)
            BR_GT:   m_next = io.a_din;
            BR_LT:   m_next = io.b_din;
            default: m_next = WIDTH'(1);
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
            s0_valid <= 1'b0;
            mul_v    <= '0;
        end else begin
            if (accept && !pop) begin
                inflight <= inflight + CNT_W'(1);
            end else if (pop && !accept) begin
                inflight <= inflight - CNT_W'(1);
            end
            s0_valid <= accept;
            mul_v[0] <= s0_valid;
            for (int i = 1; i < MUL_LAT; i++) begin
                mul_v[i] <= mul_v[i-1];
            end
        end
    end

    // Datapath registers are qualified by the valid bits above and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s0_k <= k_next;
            s0_m <= m_next;
        end
        mul_q[0] <= s0_k * s0_m;
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_q[i] <= mul_q[i-1];
        end
    end

    elastic_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (mul_v[MUL_LAT-1]),
        .wr_data (mul_q[MUL_LAT-1]),
        .rd_en   (pop),
        .rd_data (io.end_out),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(mul_v[MUL_LAT-1] && fifo_full));
    a_fifo_le_inflight: assert property (@(posedge clk) disable iff (!rst)
        fifo_count <= inflight);
endmodule

// File: tb/tb_if_else_stream.sv
// Scoreboard bench for if_else_stream: signed and unsigned instances share stimulus.
// The driver pushes expected results on accept; the monitor pops them on each pop.
module tb_if_else_stream;
    import if_else_pkg::*;

    localparam int W  = 32;
    localparam int ML = 2;
    localparam int D  = 8;

    typedef struct {
        logic [W-1:0] es;
        logic [W-1:0] eu;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_else_stream_if #(.WIDTH(W)) s_if ();
    if_else_stream_if #(.WIDTH(W)) u_if ();

    assign u_if.a_din      = s_if.a_din;
    assign u_if.a_valid_in = s_if.a_valid_in;
    assign u_if.b_din      = s_if.b_din;
    assign u_if.b_valid_in = s_if.b_valid_in;
    assign u_if.end_ready  = s_if.end_ready;

    if_else_stream #(.WIDTH(W), .MUL_LAT(ML), .DEPTH(D), .SIGNED(1'b1)) dut_s (
        .clk (clk),
        .rst (rst),
        .io  (s_if.slave)
    );

    if_else_stream #(.WIDTH(W), .MUL_LAT(ML), .DEPTH(D), .SIGNED(1'b0)) dut_u (
        .clk (clk),
        .rst (rst),
        .io  (u_if.slave)
    );

    exp_t sb [$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   tb_inflight = 0;
    int   acc_cyc = 0;
    logic hold_prev = 1'b0;
    logic [W-1:0] hold_val = '0;
    logic m_acc;
    logic m_pop;
    exp_t m_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: credit model, hold-stability checks and in-order result compare.
    always @(negedge clk) begin
        if (!rst) begin
            tb_inflight = 0;
            hold_prev   = 1'b0;
        end else begin
            check("a_ready", s_if.a_ready_out, s_if.b_valid_in && (tb_inflight < D));
            check("b_ready", s_if.b_ready_out, s_if.a_valid_in && (tb_inflight < D));
            check("inflight_max", tb_inflight <= D, 1);
            if (hold_prev) begin
                check("hold_valid", s_if.end_valid, 1);
                check("hold_data", s_if.end_out, hold_val);
            end
            m_acc = s_if.a_valid_in && s_if.b_valid_in && s_if.a_ready_out;
            m_pop = s_if.end_valid && s_if.end_ready;
            if (m_pop) begin
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    m_e = sb.pop_front();
                    n_pop++;
                    check("result_signed", s_if.end_out, m_e.es);
                    check("u_valid", u_if.end_valid, 1);
                    check("result_unsigned", u_if.end_out, m_e.eu);
                end
            end
            tb_inflight = tb_inflight + int'(m_acc) - int'(m_pop);
            hold_prev   = s_if.end_valid && !s_if.end_ready;
            hold_val    = s_if.end_out;
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle_drive(input logic av, input logic bv, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] es,
                               input logic [W-1:0] eu, output logic acc);
        exp_t e;
        s_if.a_valid_in = av;
        s_if.b_valid_in = bv;
        s_if.a_din      = a;
        s_if.b_din      = b;
        @(negedge clk);
        acc = av && bv && s_if.a_ready_out && rst;
        if (acc) begin
            e.es = es;
            e.eu = eu;
            sb.push_back(e);
            n_push++;
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] es, input logic [W-1:0] eu);
        logic acc;
        int   t;
        t = 0;
        do begin
            cycle_drive(1'b1, 1'b1, a, b, es, eu, acc);
            t++;
        end while (!acc && t < 100);
        check("send_accepted", acc, 1);
        s_if.a_valid_in = 1'b0;
        s_if.b_valid_in = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || s_if.end_valid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic         acc;
        logic         av;
        logic         bv;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           p;
        int           n;
        int           c;
        int           t;

        s_if.a_valid_in = 1'b1;
        s_if.b_valid_in = 1'b1;
        s_if.a_din      = '0;
        s_if.b_din      = '0;
        s_if.end_ready  = 1'b0;
        rst             = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_end_valid", s_if.end_valid, 0);
        check("rst_end_out", s_if.end_out, 0);
        check("rst_a_ready", s_if.a_ready_out, 0);
        check("rst_b_ready", s_if.b_ready_out, 0);

        s_if.a_valid_in = 1'b0;
        s_if.b_valid_in = 1'b0;
        s_if.end_ready  = 1'b1;
        rst             = 1'b1;
        @(posedge clk);
        #1;

        // Latency counted in cycles, the accept cycle being the first.
        send(32'd7, 32'd3, 32'd28, 32'd28);
        t = 0;
        while (!s_if.end_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("latency", cyc - acc_cyc, ML + 2);
        @(posedge clk);
        #1;
        send(32'd3, 32'd7, 32'hFFFF_FFE4, 32'hFFFF_FFE4);
        send(32'd5, 32'd5, 32'd0, 32'd0);
        send(32'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        drain();

        // Backpressure: pair i is (i+2, 1) -> GT, k = i+1, result (i+1)*(i+2).
        s_if.end_ready = 1'b0;
        p = 0;
        for (int i = 0; i < 30; i++) begin
            cycle_drive(1'b1, 1'b1, W'(p + 2), W'(1), W'((p + 1) * (p + 2)),
                        W'((p + 1) * (p + 2)), acc);
            if (acc) p++;
        end
        check("bp_accepts", p, D);
        check("bp_valid_held", s_if.end_valid, 1);
        s_if.a_valid_in = 1'b0;
        s_if.b_valid_in = 1'b0;
        s_if.end_ready  = 1'b1;
        while (p < 20) begin
            send(W'(p + 2), W'(1), W'((p + 1) * (p + 2)), W'((p + 1) * (p + 2)));
            p++;
        end
        drain();
        check("bp_push_pop", n_pop, n_push);

        // Random traffic against the golden model.
        n = 0;
        c = 0;
        while (n < 1000 && c < 20000) begin
            s_if.end_ready = 1'($urandom_range(0, 1));
            av = 1'($urandom_range(0, 1));
            bv = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            cycle_drive(av, bv, a, b, W'(ie_ref(64'(a), 64'(b), 1'b1, W)),
                        W'(ie_ref(64'(a), 64'(b), 1'b0, W)), acc);
            if (acc) n++;
            c++;
        end
        check("rand_accepts", n, 1000);
        s_if.a_valid_in = 1'b0;
        s_if.b_valid_in = 1'b0;
        s_if.end_ready  = 1'b1;
        drain();
        check("rand_push_pop", n_pop, n_push);

        // Reset with tokens in flight: pair i is (i+1, 0) -> (i+1)^2.
        s_if.end_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(W'(i + 1), W'(0), W'((i + 1) * (i + 1)), W'((i + 1) * (i + 1)));
        end
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_valid", s_if.end_valid, 1);
        #1;
        rst = 1'b0;
        #1;
        check("rst2_end_valid", s_if.end_valid, 0);
        check("rst2_end_out", s_if.end_out, 0);
        n_push = n_push - sb.size();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst            = 1'b1;
        s_if.end_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'd10, 32'd4, 32'd60, 32'd60);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", s_if.end_valid, 0);
        check("final_push_pop", n_pop, n_push);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
